// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/stream_reg_slot.sv
// One-entry registered output slot; a load in the same cycle as a drain
// keeps the slot full so a streaming consumer sees no bubble.
module stream_reg_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  logic [WIDTH:0] store;

  assign data = store[WIDTH-1:0];
  assign last = store[WIDTH];

  // Slot occupancy and payload; payload only changes on load so it holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      store <= '0;
    end else if (load) begin
      valid <= 1'b1;
      store <= {load_last, load_data};
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1ton_stream.sv
// Registered 1-to-N stream demultiplexer: steers each packet to the port
// chosen on its first beat, and discards packets whose select is out of range.
module demux1ton_stream
  import demux_pkg::*;
#(
  parameter int N     = 5,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [SELW-1:0]               in_sel,
  input  logic                          in_last,
  output logic [N-1:0]                  out_valid,
  input  logic [N-1:0]                  out_ready,
  output logic [N-1:0][WIDTH-1:0]       out_data,
  output logic [N-1:0]                  out_last,
  output logic                          drop_err,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  localparam int                    SELS    = 1 << SELW;
  localparam logic [SELW:0]         N_LIM   = (SELW+1)'(N);
  localparam logic [DROP_CNT_W-1:0] CNT_MAX = {DROP_CNT_W{1'b1}};
  localparam logic [DROP_CNT_W-1:0] CNT_ONE = DROP_CNT_W'(1);

  state_t          state;
  logic [SELW-1:0] dest;
  logic [SELW-1:0] cur_dest;
  logic            sel_ok;
  logic            in_range;
  logic            accept;
  logic            drop_done;
  logic [SELS-1:0] slot_free;
  logic [N-1:0]    load;

  // Handshake and steering: the destination is in_sel on a first beat, the latched dest afterwards.
  always_comb begin
    slot_free = '0;
    for (int k = 0; k < N; k++) begin
      slot_free[k] = ~out_valid[k] | out_ready[k];
    end
    sel_ok = ({1'b0, in_sel} < N_LIM);
    if (state == ROUTE) begin
      cur_dest = dest;
      in_range = 1'b1;
    end else begin
      cur_dest = in_sel;
      in_range = sel_ok && (state == IDLE);
    end
    in_ready  = (state == DROP) || ((state == IDLE) && !sel_ok) ||
                (in_range && slot_free[cur_dest]);
    accept    = in_valid && in_ready;
    drop_done = accept && in_last && ((state == DROP) || ((state == IDLE) && !sel_ok));
    for (int k = 0; k < N; k++) begin
      load[k] = accept && in_range && (cur_dest == SELW'(k));
    end
  end

  // Packet FSM, destination latch and saturating drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dest       <= '0;
      drop_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_err <= drop_done;
      if (drop_done && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + CNT_ONE;
      end
      case (state)
        IDLE: begin
          if (accept && !in_last) begin
            if (sel_ok) begin
              dest  <= in_sel;
              state <= ROUTE;
            end else begin
              state <= DROP;
            end
          end
        end
        ROUTE: begin
          if (accept && in_last) begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (accept && in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    stream_reg_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k]),
      .last      (out_last[k])
    );
  end

endmodule

// File: doc/demux1ton_stream.md
# demux1toN_stream

Registered 1-to-N stream demultiplexer, the write-side counterpart of the N-to-1 mux: one valid/ready input stream is steered to one of N valid/ready output ports. The destination is latched on the first beat of each packet and held until the beat carrying `in_last` is accepted. Every output port has a one-entry register slot. It sits between a single producer, such as a decode stage, and N parallel consumers.

## Interface
Parameters:
- `N`, 5: number of output ports; legal range N >= 2.
- `WIDTH`, 8: data width in bits.
- `SELW`, $clog2(N): select width; derived, not overridden.

Ports (clock and reset are decided: one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted this cycle when high with `in_valid`.
- `in_data`  in  WIDTH  input payload.
- `in_sel`  in  SELW  destination; sampled only on the first beat of a packet.
- `in_last`  in  1  final beat of packet.
- `out_valid`  out  N  per-port slot full.
- `out_ready`  in  N  per-port consumer ready.
- `out_data`  out  [N][WIDTH]  per-port payload.
- `out_last`  out  N  per-port last flag.
- `drop_err`  out  1  one-cycle pulse when a packet with out-of-range select completes.
- `drop_count`  out  8  saturating count of dropped packets.

## Operation
- FSM with states IDLE, ROUTE, DROP.
- IDLE:
  - `in_sel` is used directly as the destination.
  - First beat accepted, `in_sel` < N, `in_last`=0: latch `dest`, go to ROUTE.
  - First beat accepted, `in_sel` >= N, `in_last`=0: go to DROP.
  - Single-beat packet (`in_last`=1): stay in IDLE.
- ROUTE: beats go to the latched `dest`; `in_sel` is ignored. Accepting a beat with `in_last`=1 returns to IDLE.
- DROP: `in_ready`=1 and beats are discarded. Accepting the last beat returns to IDLE.
- Out-of-range packets, including single-beat ones from IDLE:
  - `drop_err` pulses in the cycle after the last beat is accepted.
  - `drop_count` increments and saturates at 255.
- Output slot k loads when an input beat is accepted with destination k. It clears when `out_valid[k]` and `out_ready[k]` are both high and no load occurs in the same cycle.
- `in_ready` = (state==DROP) or (destination is in range and (slot empty or `out_ready[dest]`)).
- `in_ready` is combinational from `out_ready[dest]` and must not depend on `in_valid`.
- Destination for the `in_ready` term: `in_sel` in IDLE, `dest` in ROUTE.
- Out-of-range `in_sel` in IDLE: `in_ready`=1.
- Slots other than the current destination drain independently.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `drop_err`=0, `drop_count`=0.
- Immediately after reset, `in_ready`=1 when `in_sel` < N.
- Latency: a beat accepted at edge t appears on `out_valid[dest]` after edge t, i.e. 1 cycle.
- Throughput: 1 beat/cycle while the destination consumer holds `out_ready`=1.
- Simultaneous drain and load on the same slot: the slot stays full with the new beat; there is no bubble.
- `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- `rst` asserted mid-packet: state returns to IDLE, all slots clear, and any partial packet is abandoned. The next accepted beat is treated as a first beat.
- `in_sel` changing mid-packet has no effect.

## Structure
- Package `demux_pkg`:
  - `state_t` enum (IDLE, ROUTE, DROP).
  - `DROP_CNT_W` = 8.
- Sub-module `stream_reg_slot`: one-entry registered slot with `clk`/`rst`, load and drain handshake, and `WIDTH`+1 bits of storage. The top instantiates it N times.
- The top holds the FSM, `dest` register, ready logic and drop counter.

## Test plan
1. N=5, WIDTH=8, all `out_ready`=1; single-beat packets with sel 0..4 and data 10..14 -> `out_data[j]`=10+j with `out_valid[j]` one cycle after acceptance; no other port valid.
2. 3-beat packet, sel=2, data 0xA1/0xA2/0xA3, `in_sel` changed to 4 on beats 2-3 -> all three beats exit port 2 in order; `out_last[2]` only on 0xA3; port 4 stays idle.
3. `out_ready[1]`=0 for 4 cycles during a packet to port 1 -> `in_ready`=0 while the slot is full; `out_data[1]` stable; after release, 1 beat/cycle with no loss.
4. sel=7 on a 2-beat packet -> `in_ready`=1 on both beats; no `out_valid`; `drop_err` pulses once; `drop_count`=1. Then 256 further bad packets -> `drop_count` holds 255.
5. `rst` pulsed on beat 2 of a 4-beat packet to port 3 -> all outputs at reset values; next beat with sel=0 routes to port 0.
6. Port 0 slot stalled full while a packet to port 3 streams -> port 3 receives at full rate; port 0 data unchanged.
